// File: rtl/random_box_picker.sv
// random_box_picker: pseudo-random box index generator for the whack-a-mole
// display path. A free-running Fibonacci LFSR supplies candidates. Candidates
// that are out of range are rejected and redrawn. After MAX_TRIES rejections a
// deterministic fallback box is used instead. Each drawn box is presented on a
// valid/ack handshake. A draw starts on req, or on the periodic auto tick when
// auto_en is high.
// Optional feature macro: RANDOM_BOX_NO_REPEAT_EN. When it is defined, a
// candidate equal to the previously presented box is also rejected.
module random_box_picker #(
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] TAPS      = 8'hB8,
    parameter int                NUM_BOXES = 6,
    parameter int                BOX_W     = 3,
    parameter int                TICK_DIV  = 50000000,
    parameter int                MAX_TRIES = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              seed_load,
    input  logic              auto_en,
    input  logic              req,
    input  logic              box_ack,
    output logic [BOX_W-1:0]  box,
    output logic              box_valid,
    output logic              busy,
    output logic [LFSR_W-1:0] lfsr_state
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TRY_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);
    localparam logic [TRY_W-1:0]  TRY_LAST    = TRY_W'(MAX_TRIES - 1);
    // One bit wider than a box index so that NUM_BOXES == 2**BOX_W still fits.
    localparam logic [BOX_W:0]    NB_EXT      = (BOX_W + 1)'(NUM_BOXES);
    localparam logic [BOX_W-1:0]  LAST_BOX    = BOX_W'(NUM_BOXES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAW    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]   cnt_q, cnt_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [TRY_W-1:0]    tries_q, tries_d;
    logic [BOX_W-1:0]    box_q, box_d;
    logic                box_valid_q, box_valid_d;
    logic [BOX_W-1:0]    last_box_q, last_box_d;
    logic                last_valid_q, last_valid_d;

    logic                tick;
    logic [LFSR_W-1:0]   lfsr_step;
    logic [LFSR_W-1:0]   seed_val;
    logic [BOX_W-1:0]    candidate;
    logic                in_range;
    logic                cand_ok;
    logic [BOX_W-1:0]    fallback;

    // Free-running LFSR, seed counter and auto-draw tick divider.
    always_comb begin
        lfsr_step = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
        // A zero seed would lock the LFSR at zero, so it is replaced by 1.
        seed_val  = (cnt_q == '0) ? LFSR_W'(1) : cnt_q;
        lfsr_d    = seed_load ? seed_val : lfsr_step;
        cnt_d     = cnt_q + 1'b1;
        tick      = (tick_q == '0);
        tick_d    = tick ? TICK_RELOAD : tick_q - 1'b1;
    end

    // Candidate qualification and the fallback box used when tries run out.
    always_comb begin
        candidate = lfsr_q[BOX_W-1:0];
        in_range  = ({1'b0, candidate} < NB_EXT);
`ifdef RANDOM_BOX_NO_REPEAT_EN
        cand_ok   = in_range && !(last_valid_q && (candidate == last_box_q));
`else
        cand_ok   = in_range;
`endif
        if (!last_valid_q || (last_box_q == LAST_BOX)) begin
            fallback = '0;
        end else begin
            fallback = last_box_q + 1'b1;
        end
    end

    // Draw FSM next-state logic. The fallback box is also recorded as the last
    // box, so consecutive presented boxes are compared against what was shown.
    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        box_d        = box_q;
        box_valid_d  = box_valid_q;
        last_box_d   = last_box_q;
        last_valid_d = last_valid_q;
        case (state_q)
            S_IDLE: begin
                if (req || (auto_en && tick)) begin
                    state_d = S_DRAW;
                    tries_d = '0;
                end
            end
            S_DRAW: begin
                if (cand_ok) begin
                    box_d        = candidate;
                    last_box_d   = candidate;
                    last_valid_d = 1'b1;
                    box_valid_d  = 1'b1;
                    state_d      = S_PRESENT;
                end else if (tries_q == TRY_LAST) begin
                    box_d        = fallback;
                    last_box_d   = fallback;
                    last_valid_d = 1'b1;
                    box_valid_d  = 1'b1;
                    state_d      = S_PRESENT;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            S_PRESENT: begin
                // Requests arriving here are dropped, not queued.
                if (box_ack) begin
                    box_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_W'(1);
            cnt_q        <= '0;
            tick_q       <= TICK_RELOAD;
            tries_q      <= '0;
            box_q        <= '0;
            box_valid_q  <= 1'b0;
            last_box_q   <= '0;
            last_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            tries_q      <= tries_d;
            box_q        <= box_d;
            box_valid_q  <= box_valid_d;
            last_box_q   <= last_box_d;
            last_valid_q <= last_valid_d;
        end
    end

    assign box        = box_q;
    assign box_valid  = box_valid_q;
    assign busy       = (state_q == S_DRAW);
    assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_random_box_picker.sv
// Bench for random_box_picker: a cycle-level reference model built from the
// behavioural rules (cycle count since reset, LFSR recurrence, draw/present
// rules) is compared with the DUT on every falling edge, alongside directed
// vectors with hand-computed values.
module tb_random_box_picker;

    localparam int NB  = 6;
    localparam int MT  = 4;
    localparam int TD  = 10;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       seed_load = 1'b0;
    logic       auto_en = 1'b0;
    logic       req = 1'b0;
    logic       box_ack = 1'b0;
    logic [2:0] box;
    logic       box_valid;
    logic       busy;
    logic [7:0] lfsr_state;

    int n_vec  = 0;
    int n_fail = 0;

    random_box_picker #(
        .LFSR_W(8), .TAPS(8'hB8), .NUM_BOXES(NB), .BOX_W(3),
        .TICK_DIV(TD), .MAX_TRIES(MT)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .seed_load(seed_load),
        .auto_en(auto_en), .req(req), .box_ack(box_ack), .box(box),
        .box_valid(box_valid), .busy(busy), .lfsr_state(lfsr_state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // ---------------- reference model ----------------
    int         mn;          // rising edges since reset release
    logic [7:0] m_lfsr;
    int         m_phase;     // 0 waiting, 1 drawing, 2 presenting
    int         m_tries;
    int         m_box;
    bit         m_valid;
    int         m_last;
    bit         m_has_last;

    function automatic logic [7:0] lnext(logic [7:0] s);
        return {s[6:0], ^(s & 8'hB8)};
    endfunction

    function automatic bit accepts(int cand, bit has_last, int last);
        bit ok;
        ok = (cand < NB);
`ifdef RANDOM_BOX_NO_REPEAT_EN
        if (has_last && cand == last) ok = 1'b0;
`endif
        return ok;
    endfunction

    task automatic model_reset();
        mn = 0; m_lfsr = 8'h01; m_phase = 0; m_tries = 0;
        m_box = 0; m_valid = 1'b0; m_last = 0; m_has_last = 1'b0;
    endtask

    task automatic model_present(int b);
        m_box = b; m_valid = 1'b1; m_last = b; m_has_last = 1'b1; m_phase = 2;
    endtask

    task automatic model_edge();
        bit tick;
        int cnt;
        int cand;
        tick = (((mn + 1) % TD) == 0);
        cnt  = mn % 256;
        cand = int'(m_lfsr) % 8;
        if (m_phase == 0) begin
            if (req || (auto_en && tick)) begin m_phase = 1; m_tries = 0; end
        end else if (m_phase == 1) begin
            if (accepts(cand, m_has_last, m_last)) model_present(cand);
            else if (m_tries + 1 >= MT) model_present(m_has_last ? (m_last + 1) % NB : 0);
            else m_tries++;
        end else begin
            if (box_ack) begin m_valid = 1'b0; m_phase = 0; end
        end
        m_lfsr = seed_load ? ((cnt == 0) ? 8'h01 : 8'(cnt)) : lnext(m_lfsr);
        mn++;
    endtask

    initial forever begin
        @(posedge CLOCK_50 or posedge reset);
        if (reset) model_reset();
        else model_edge();
    end

    // ---------------- checking ----------------
    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (!reset) begin
            check("cyc_lfsr", int'(lfsr_state), int'(m_lfsr));
            check("cyc_busy", int'(busy), int'(m_phase == 1));
            check("cyc_valid", int'(box_valid), int'(m_valid));
            if (m_valid) check("cyc_box", int'(box), m_box);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cnt(int c);
        int g;
        g = 0;
        while ((mn % 256) != c && g < 300) begin @(negedge CLOCK_50); g++; end
        if ((mn % 256) != c) check("wait_cnt_timeout", mn % 256, c);
    endtask

    function automatic int find_seed(int rej, int avoid);
        logic [7:0] s;
        bit good;
        for (int c = 1; c < 256; c++) begin
            s = 8'(c);
            good = 1'b1;
            for (int i = 0; i < rej; i++) begin
                if ((int'(s) % 8) < NB) good = 1'b0;
                s = lnext(s);
            end
            if (rej < MT && ((int'(s) % 8) >= NB || (int'(s) % 8) == avoid)) good = 1'b0;
            if (good) return c;
        end
        return 0;
    endfunction

    function automatic int cand_after(int c, int rej);
        logic [7:0] s;
        s = 8'(c);
        for (int i = 0; i < rej; i++) s = lnext(s);
        return int'(s) % 8;
    endfunction

    task automatic seeded_draw(string name, int c, int exp_box, int exp_lat, int hold);
        int lat;
        wait_cnt(c);
        seed_load = 1'b1; req = 1'b1;
        @(negedge CLOCK_50);
        seed_load = 1'b0; req = 1'b0;
        check({name, "_seed"}, int'(lfsr_state), c);
        check({name, "_busy"}, int'(busy), 1);
        lat = 1;
        while (!box_valid && lat < 20) begin @(negedge CLOCK_50); lat++; end
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_box"}, int'(box), exp_box);
        if (hold > 0) begin
            repeat (hold) @(negedge CLOCK_50);
            check({name, "_hold_box"}, int'(box), exp_box);
            check({name, "_hold_valid"}, int'(box_valid), 1);
        end
        box_ack = 1'b1;
        @(negedge CLOCK_50);
        box_ack = 1'b0;
        check({name, "_ack_valid"}, int'(box_valid), 0);
    endtask

    task automatic do_draw(output int b);
        int k;
        req = 1'b1;
        @(negedge CLOCK_50);
        req = 1'b0;
        k = 0;
        while (!box_valid && k < 20) begin @(negedge CLOCK_50); k++; end
        if (!box_valid) check("draw_timeout", int'(box_valid), 1);
        b = int'(box);
        box_ack = 1'b1;
        @(negedge CLOCK_50);
        box_ack = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  first_ret;
        int  zero_seen;
        int  c;
        int  exp_b;
        int  b;
        int  prev;
        int  repeats;
        int  bad;
        int  occ [NB];
        int  seen_all;
        int  nv;

        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        check("rst_lfsr", int'(lfsr_state), 8'h01);
        check("rst_valid", int'(box_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_box", int'(box), 0);
        reset = 1'b0;

        // Free-run: 0x01 -> 0x02 -> 0x04 -> 0x08 -> 0x11.
        @(negedge CLOCK_50); check("run1", int'(lfsr_state), 8'h02);
        @(negedge CLOCK_50); check("run2", int'(lfsr_state), 8'h04);
        @(negedge CLOCK_50); check("run3", int'(lfsr_state), 8'h08);
        @(negedge CLOCK_50); check("run4", int'(lfsr_state), 8'h11);

        // Period: first return to the start value after exactly 255 steps.
        first_ret = 0; zero_seen = 0;
        begin
            logic [7:0] v0;
            v0 = lfsr_state;
            for (int i = 1; i <= 300 && first_ret == 0; i++) begin
                @(negedge CLOCK_50);
                if (lfsr_state == 8'h00) zero_seen = 1;
                if (lfsr_state == v0) first_ret = i;
            end
        end
        check("period", first_ret, 255);
        check("no_zero_state", zero_seen, 0);

        // Seed capture with counter 0 yields 1 instead of 0.
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0; seed_load = 1'b1;
        @(negedge CLOCK_50);
        seed_load = 1'b0;
        check("seed_zero", int'(lfsr_state), 8'h01);

        // No prior box: fallback after MAX_TRIES rejections is 0.
        c = find_seed(MT, -1);
        if (c == 0) check("seed_search_fb0", c, 1);
        else seeded_draw("fallback0", c, 0, MT + 1, 0);

        // Seed capture with counter 0x5A.
        wait_cnt(8'h5A);
        seed_load = 1'b1;
        @(negedge CLOCK_50);
        seed_load = 1'b0;
        check("seed_5a", int'(lfsr_state), 8'h5A);

        // Best case: seed 0x23 has low bits 3, accepted at once; hold 10 cycles.
        seeded_draw("box3", 8'h23, 3, 2, 10);

        // Fallback after last box 3 gives 4.
        c = find_seed(MT, -1);
        if (c == 0) check("seed_search_fb4", c, 1);
        else seeded_draw("fallback4", c, 4, MT + 1, 0);

        // Three rejections, then an in-range candidate.
        c = find_seed(3, 4);
        if (c == 0) check("seed_search_rej3", c, 1);
        else begin
            exp_b = cand_after(c, 3);
            seeded_draw("rej3", c, exp_b, 5, 0);
        end

        // Bulk request/ack draws.
        prev = -1; repeats = 0; bad = 0;
        for (int i = 0; i < NB; i++) occ[i] = 0;
        for (int i = 0; i < 1000; i++) begin
            do_draw(b);
            if (b >= NB) bad++;
            else occ[b]++;
            if (b == prev) repeats++;
            prev = b;
            repeat ($urandom_range(0, 2)) @(negedge CLOCK_50);
        end
        check("bulk_out_of_range", bad, 0);
        seen_all = 1;
        for (int i = 0; i < NB; i++) if (occ[i] == 0) seen_all = 0;
        check("bulk_all_values", seen_all, 1);
`ifdef RANDOM_BOX_NO_REPEAT_EN
        check("bulk_no_repeat", repeats, 0);
`else
        check("bulk_repeats_seen", int'(repeats > 0), 1);
`endif

        // Auto-draw: one presentation per tick period with ack held high.
        box_ack = 1'b1; auto_en = 1'b1;
        repeat (30) @(negedge CLOCK_50);
        nv = 0;
        repeat (100) begin @(negedge CLOCK_50); if (box_valid) nv++; end
        check("auto_draws_100", nv, 10);
        auto_en = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        nv = 0;
        repeat (100) begin @(negedge CLOCK_50); if (box_valid) nv++; end
        check("auto_off_draws", nv, 0);
        box_ack = 1'b0;

        // Asynchronous reset in the middle of a draw.
        req = 1'b1;
        @(posedge CLOCK_50);
        #2;
        check("mid_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("areset_busy", int'(busy), 0);
        check("areset_valid", int'(box_valid), 0);
        check("areset_lfsr", int'(lfsr_state), 8'h01);
        req = 1'b0;
        @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        check("post_reset_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
